// File: rtl/priority_arbiter_4.sv
// priority_arbiter_4: four-requester arbiter with registered one-hot grant,
// bounded ownership (MAX_HOLD cycles) and a one-cycle turnaround gap
// between owners.
//
// Build option: define ARB_ROUND_ROBIN_EN to replace the fixed priority
// (req[3] highest .. req[0] lowest) with rotating priority, where the
// most recent owner drops to lowest priority.
//
// Handshake: req[i] is a level-sensitive request held by requester i for
// as long as it wants the resource; gnt[i] is the registered answer.
// Ownership ends on the first edge that samples req[owner] low, or after
// MAX_HOLD grant cycles (timeout pulses for that release only). Every
// release is followed by exactly one GAP cycle with gnt = 0.
module priority_arbiter_4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout,
  output logic [1:0] state_dbg
);

  localparam int CW = $clog2(MAX_HOLD) + 1;
  // hold_cnt starts at 0 on the first grant cycle, so this is the last one.
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] hold_nxt;
  logic [3:0]    gnt_nxt;
  logic [1:0]    id_nxt;
  logic          timeout_nxt;
  logic [1:0]    winner;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0]    last_owner;
  logic [1:0]    last_nxt;

  // Rotating search: last_owner-1, -2, -3 (mod 4), then last_owner itself.
  always_comb begin
    logic       found;
    logic [1:0] cand;
    winner = last_owner;
    found  = 1'b0;
    cand   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_owner - 2'(k);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end
`else
  // Fixed priority: req[3] wins over everything, req[0] loses to everything.
  always_comb begin
    winner = 2'd0;
    if (req[3])      winner = 2'd3;
    else if (req[2]) winner = 2'd2;
    else if (req[1]) winner = 2'd1;
    else             winner = 2'd0;
  end
`endif

  // Next-state and next-output logic for the IDLE/GRANT/GAP controller.
  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    gnt_nxt     = gnt;
    id_nxt      = gnt_id;
    timeout_nxt = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_nxt    = last_owner;
`endif
    case (state)
      IDLE, GAP: begin
        if (req != 4'b0000) begin
          state_nxt = GRANT;
          gnt_nxt   = 4'(1) << winner;
          id_nxt    = winner;
          hold_nxt  = '0;
`ifdef ARB_ROUND_ROBIN_EN
          last_nxt  = winner;
`endif
        end else begin
          state_nxt = IDLE;
          gnt_nxt   = 4'b0000;
          id_nxt    = 2'd0;
        end
      end
      GRANT: begin
        if (!req[gnt_id]) begin
          // Owner let go voluntarily: turnaround without timeout.
          state_nxt = GAP;
          gnt_nxt   = 4'b0000;
          id_nxt    = 2'd0;
        end else if (hold_cnt == HOLD_LAST) begin
          // Owner used its full budget: force release and flag it.
          state_nxt   = GAP;
          gnt_nxt     = 4'b0000;
          id_nxt      = 2'd0;
          timeout_nxt = 1'b1;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
        id_nxt    = 2'd0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= IDLE;
      hold_cnt <= '0;
      gnt      <= 4'b0000;
      gnt_id   <= 2'd0;
      timeout  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner <= 2'd0;
`endif
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      gnt_id   <= id_nxt;
      timeout  <= timeout_nxt;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner <= last_nxt;
`endif
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_priority_arbiter_4.sv
// tb_priority_arbiter_4: directed scenarios plus random request traffic,
// checked every cycle against an ownership-level model of the arbiter.
module tb_priority_arbiter_4;

  localparam int MAX_HOLD = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rstN;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  priority_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .timeout   (timeout),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Ownership view: who owns the bus (-1 = nobody), how many grant cycles
  // that owner has been shown, whether we are in the turnaround cycle.
  int m_owner = -1;
  int m_held  = 0;
  int m_last  = 0;
  bit m_gap   = 0;
  bit m_tmo   = 0;

  function automatic int pick(input logic [3:0] r, input int last);
    int order[4];
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      order[k] = (last - (k + 1) + 8) % 4;
`else
      order[k] = 3 - k;
`endif
    end
    for (int k = 0; k < 4; k++)
      if (r[order[k]]) return order[k];
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_last = 0; m_gap = 0; m_tmo = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    m_tmo = 0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_owner = -1; m_gap = 1;
      end else if (m_held == MAX_HOLD) begin
        m_owner = -1; m_gap = 1; m_tmo = 1;
      end else begin
        m_held++;
      end
    end else begin
      m_gap = 0;
      if (r != 4'b0000) begin
        m_owner = pick(r, m_last);
        m_last  = m_owner;
        m_held  = 1;
      end
    end
  endtask

  function automatic logic [7:0] model_expect();
    logic [7:0] e;
    e = 8'h00;
    if (m_owner >= 0) begin
      e[3:0] = 4'(1 << m_owner);
      e[5:4] = 2'(m_owner);
    end
    e[6] = m_tmo;
    e[7] = (m_owner >= 0) || m_gap;
    return e;
  endfunction

  // ---------------- driver ----------------
  // Drive req for one clock, advance the model, then compare just after the edge.
  task automatic cycle(input logic [3:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_step(r);
    exp_q.push_back(model_expect());
    #1;
    check_eq(tag, {24'd0, busy, timeout, gnt_id, gnt}, {24'd0, exp_q.pop_front()});
    check_eq({tag, "_onehot"}, 32'($countones(gnt) <= 1), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] r;
    rstN = 1'b0;
    req  = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_out", {24'd0, busy, timeout, gnt_id, gnt}, {24'd0, model_expect()});
    @(negedge clk);
    rstN = 1'b1;
    #1;

    // First grant from IDLE, owner 2 drops after 3 grant cycles, then owner 1.
    cycle(4'b0110, "first_grant");
    cycle(4'b0110, "hold2_a");
    cycle(4'b0110, "hold2_b");
    cycle(4'b0010, "drop_gap");
    cycle(4'b0010, "grant1");
    cycle(4'b0000, "release1");
    cycle(4'b0000, "idle");

    // Owner 3 held to timeout; req[0] shows up mid-grant without pre-empting.
    cycle(4'b1000, "grant3");
    for (int i = 0; i < 3; i++) cycle(4'b1001, "no_preempt");
    for (int i = 0; i < 6; i++) cycle(4'b1000, "hold3_timeout");
    cycle(4'b1000, "regrant3");
    cycle(4'b0000, "gap_after3");
    cycle(4'b0000, "idle2");

    // All requesters active: rotation (or fixed winner) with gaps between.
    for (int i = 0; i < 12; i++) cycle(4'b1111, "all_req");
    cycle(4'b0000, "drain_a");
    cycle(4'b0000, "drain_b");

    // Reset asserted between edges while owning.
    cycle(4'b1000, "pre_reset_grant");
    cycle(4'b1000, "pre_reset_hold");
    #2;
    rstN = 1'b0;
    #1;
    model_reset();
    check_eq("async_reset_gnt",  {28'd0, gnt}, {28'd0, model_expect()[3:0]});
    check_eq("async_reset_busy", {31'd0, busy}, {31'd0, model_expect()[7]});
    @(negedge clk);
    rstN = 1'b1;
    cycle(4'b1000, "regrant_after_reset");
    cycle(4'b0000, "post_reset_gap");

    // Random traffic, requests tend to persist so timeouts occur.
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 4) r = 4'($urandom_range(0, 15));
      cycle(r, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/priority_arbiter_4.md
PRIORITY_ARBITER_4 -- requirements
Module: priority_arbiter_4

Interface
REQ-001 The module SHALL have parameter MAX_HOLD, default 8, meaning the maximum number of consecutive grant cycles per ownership; legal range 2..255.
REQ-002 The module SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rstN  input  1  reset, asynchronous and active-low.
REQ-004 The module SHALL have port req  input  4  per-requester request; req[i] high means requester i wants the shared resource.
REQ-005 The module SHALL have port gnt  output  4  one-hot grant, registered; all-zero when no owner.
REQ-006 The module SHALL have port gnt_id  output  2  binary index of the current owner; 0 when gnt is all-zero.
REQ-007 The module SHALL have port busy  output  1  high whenever the FSM is in GRANT or GAP.
REQ-008 The module SHALL have port timeout  output  1  single-cycle pulse when an ownership is force-released at MAX_HOLD.

Function
REQ-009 The module SHALL implement a three-state FSM: IDLE, GRANT and GAP.
REQ-010 In IDLE and GAP, on a clock edge with req != 0, the module SHALL latch the winner per REQ-016/REQ-017, enter GRANT and assert gnt[winner] on that same edge (1-cycle req-to-gnt latency from IDLE).
REQ-011 In IDLE and GAP, with req == 0, the module SHALL go to or stay in IDLE with gnt = 0.
REQ-012 In GRANT, the module SHALL increment a hold counter (width $clog2(MAX_HOLD)+1, cleared on entry to GRANT) every cycle and keep gnt and gnt_id stable.
REQ-013 In GRANT, if req[owner] is sampled low, the module SHALL enter GAP on that edge and drive gnt = 0, with no timeout pulse.
REQ-014 In GRANT, when the owner has held gnt for MAX_HOLD cycles with req[owner] still high, the module SHALL enter GAP, drive gnt = 0 and pulse timeout for exactly one cycle.
REQ-015 GAP SHALL last exactly one cycle with gnt = 0 (bus turnaround); arbitration in GAP SHALL use req sampled during that cycle.
REQ-016 Without the REQ-021 macro, priority SHALL be fixed: req[3] highest, then req[2], req[1], req[0] lowest.
REQ-017 Requests from non-owners during GRANT SHALL NOT pre-empt the owner; they are only considered in IDLE or GAP.
REQ-018 gnt SHALL be one-hot or zero in every cycle; gnt_id SHALL equal the index of the set gnt bit.
REQ-019 A timed-out requester still requesting SHALL be eligible in the following GAP under normal priority rules; under fixed priority it may win again.

Reset
REQ-020 On rstN low, the module SHALL immediately, regardless of clk, force state IDLE, gnt = 4'b0000, gnt_id = 2'd0, busy = 0, timeout = 0, hold counter = 0 and last-owner register = 0; this includes assertion mid-GRANT, and arbitration SHALL resume on the first rising clk after rstN returns high.

Configuration
REQ-021 When macro ARB_ROUND_ROBIN_EN is defined, priority SHALL rotate as follows: after a grant to N, N becomes lowest, and the search order is N-1, N-2, N-3 (mod 4), then N; the last-owner reset value of 0 gives an initial order of 3,2,1,0. When the macro is not defined, the fixed priority of REQ-016 SHALL apply and the last-owner register need not exist.

Verification (MAX_HOLD = 8)
REQ-022 The bench SHALL cover: reset, then req=4'b0110 held -> 1 cycle later gnt=4'b0100, gnt_id=2, busy=1.
REQ-023 The bench SHALL cover: owner 2 drops req after 3 grant cycles -> next edge gnt=0 (GAP); with req=4'b0010 the following edge gives gnt=4'b0010.
REQ-024 The bench SHALL cover: req=4'b1000 held continuously -> gnt=4'b1000 for exactly 8 cycles, then gnt=0 with timeout=1 for 1 cycle; without the macro, gnt=4'b1000 again next cycle.
REQ-025 The bench SHALL cover: with ARB_ROUND_ROBIN_EN, req=4'b1111 held -> grant sequence 3,2,1,0,3, each separated by one GAP cycle.
REQ-026 The bench SHALL cover: req[0] asserted during an owner-3 GRANT -> gnt stays 4'b1000, with no pre-emption.
REQ-027 The bench SHALL cover: rstN pulsed low mid-GRANT between clock edges -> gnt=0, busy=0 immediately, and re-grant 1 cycle after release.
